// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage: radix-2 shift-add multiply and
// restoring divide, one bit per cycle. Optional macro MULDIV_EARLY_OUT_EN skips BUSY for trivial ops.
module ex_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [9:0]      func_i,
  input  logic [XLEN-1:0] data1_i,
  input  logic [XLEN-1:0] data2_i,
  input  logic [4:0]      WRRD_i,
  input  logic            RegWrite_i,
  output logic            stall_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      WRRD_o,
  output logic            RegWrite_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]     a_q, a_d, b_q, b_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [2:0]          f3_q, f3_d;
  logic                sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic                div0_q, div0_d, ovf_q, ovf_d, zero_q, zero_d;
  logic [4:0]          wrrd_q, wrrd_d;
  logic                rw_q, rw_d;
  logic [XLEN-1:0]     result_q, result_d;

  logic                accept;
  logic [2:0]          f3_in;
  logic                is_div_in, sgn_a_in, sgn_b_in, neg_a_in, neg_b_in;
  logic [XLEN-1:0]     mag_a_in, mag_b_in;
  logic                div0_in, ovf_in, zero_in, early_in;

  assign f3_in     = func_i[2:0];
  assign is_div_in = f3_in[2];
  assign accept    = start_i && (func_i[9:3] == 7'b0000001) && (state_q == IDLE);
  assign sgn_a_in  = is_div_in ? ~f3_in[0] : (f3_in != 3'b011);
  assign sgn_b_in  = is_div_in ? ~f3_in[0] : ~f3_in[1];
  assign neg_a_in  = sgn_a_in & data1_i[XLEN-1];
  assign neg_b_in  = sgn_b_in & data2_i[XLEN-1];
  assign mag_a_in  = neg_a_in ? -data1_i : data1_i;
  assign mag_b_in  = neg_b_in ? -data2_i : data2_i;
  assign div0_in   = is_div_in && (data2_i == '0);
  assign ovf_in    = is_div_in && ~f3_in[0] && (data1_i == {1'b1, {(XLEN-1){1'b0}}})
                     && (data2_i == '1);
  assign zero_in   = ~is_div_in && ((data1_i == '0) || (data2_i == '0));

`ifdef MULDIV_EARLY_OUT_EN
  assign early_in  = div0_in | ovf_in | zero_in;
`else
  assign early_in  = 1'b0;
`endif

  // Multiply step: add multiplicand into the upper half when the multiplier LSB is set, then shift right.
  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_next;
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

  // Divide step: shift in the next dividend bit and subtract the divisor if it fits.
  logic [XLEN:0]       div_top, div_diff;
  logic [2*XLEN-1:0]   div_next;
  assign div_top  = acc_q[2*XLEN-1:XLEN-1];
  assign div_diff = div_top - {1'b0, b_q};
  assign div_next = div_diff[XLEN] ? {div_top[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

  logic [2*XLEN-1:0]   prod;
  logic [XLEN-1:0]     quo_s, rem_s, fix;
  assign prod  = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
  assign quo_s = (sign_a_q ^ sign_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem_s = sign_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

  always_comb begin
    fix = '0;
    if (!f3_q[2]) begin
      if (!zero_q) fix = (f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end else if (div0_q) begin
      fix = f3_q[1] ? (sign_a_q ? -a_q : a_q) : '1;
    end else if (ovf_q) begin
      fix = f3_q[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end else begin
      fix = f3_q[1] ? rem_s : quo_s;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    f3_d     = f3_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    div0_d   = div0_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    wrrd_d   = wrrd_q;
    rw_d     = rw_q;
    result_d = result_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          a_d      = mag_a_in;
          b_d      = mag_b_in;
          acc_d    = is_div_in ? {{XLEN{1'b0}}, mag_a_in} : {{XLEN{1'b0}}, mag_b_in};
          f3_d     = f3_in;
          sign_a_d = neg_a_in;
          sign_b_d = neg_b_in;
          div0_d   = div0_in;
          ovf_d    = ovf_in;
          zero_d   = zero_in;
          wrrd_d   = WRRD_i;
          rw_d     = RegWrite_i;
          cnt_d    = '0;
          state_d  = early_in ? DONE : BUSY;
        end
      end
      BUSY: begin
        acc_d = f3_q[2] ? div_next : mul_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN-1)) state_d = DONE;
      end
      DONE: begin
        result_d = fix;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      f3_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      wrrd_q   <= '0;
      rw_q     <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      f3_q     <= f3_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      div0_q   <= div0_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      wrrd_q   <= wrrd_d;
      rw_q     <= rw_d;
      result_q <= result_d;
    end
  end

  assign valid_o    = (state_q == DONE);
  assign stall_o    = rst_i & (accept | (state_q == BUSY));
  assign result_o   = valid_o ? fix : result_q;
  assign WRRD_o     = wrrd_q;
  assign RegWrite_o = rw_q & valid_o;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed vector table, control/reset sequences and
// randomized ops checked against an arithmetic reference model.
module tb_ex_muldiv_unit;

  localparam int XLEN = 32;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b0;
  logic            start_i = 1'b0;
  logic [9:0]      func_i = '0;
  logic [XLEN-1:0] data1_i = '0;
  logic [XLEN-1:0] data2_i = '0;
  logic [4:0]      WRRD_i = '0;
  logic            RegWrite_i = 1'b0;
  logic            stall_o, valid_o, RegWrite_o;
  logic [XLEN-1:0] result_o;
  logic [4:0]      WRRD_o;

  int checkCount = 0;
  int passCount  = 0;
  int cyc        = 0;
  int lastValidCyc = 0;

  ex_muldiv_unit #(.XLEN(XLEN), .CNT_W(6)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .func_i(func_i),
    .data1_i(data1_i), .data2_i(data2_i), .WRRD_i(WRRD_i), .RegWrite_i(RegWrite_i),
    .stall_o(stall_o), .valid_o(valid_o), .result_o(result_o),
    .WRRD_o(WRRD_o), .RegWrite_o(RegWrite_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[14];

  // Reference model straight from the RV32M definitions using 64-bit integer arithmetic.
  function automatic logic [31:0] refModel(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub, p;
    logic            ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int expLatency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    if (!f3[2] && (a == 0 || b == 0)) return 1;
    if (f3[2] && b == 0) return 1;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`endif
    return XLEN + 1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd, input logic rw);
    @(posedge clk_i);
    #1;
    start_i    = 1'b1;
    func_i     = {7'b0000001, f3};
    data1_i    = a;
    data2_i    = b;
    WRRD_i     = rd;
    RegWrite_i = rw;
  endtask

  // Issue one op, hold it in ID/EX until the result appears, and check timing and outputs.
  task automatic runOp(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic rw, input logic [31:0] exp,
                       input string name, input bit chain);
    int lat, stallCnt, expLat;
    bit got;
    expLat   = expLatency(f3, a, b);
    lat      = 99;
    stallCnt = 0;
    got      = 1'b0;
    applyStimulus(f3, a, b, rd, rw);
    for (int n = 0; n < 45 && !got; n++) begin
      @(negedge clk_i);
      if (valid_o) begin
        got = 1'b1;
        lat = n;
        lastValidCyc = cyc;
      end else if (stall_o) begin
        stallCnt++;
      end
    end
    checkOutput({name, " latency"}, lat, expLat);
    checkOutput({name, " stall cycles"}, stallCnt, expLat);
    checkOutput({name, " stall in DONE"}, {31'd0, stall_o}, 32'd0);
    checkOutput({name, " result"}, result_o, exp);
    checkOutput({name, " WRRD"}, {27'd0, WRRD_o}, {27'd0, rd});
    checkOutput({name, " RegWrite"}, {31'd0, RegWrite_o}, {31'd0, rw});
    if (!chain) begin
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
      @(negedge clk_i);
      checkOutput({name, " stall after"}, {31'd0, stall_o}, 32'd0);
      checkOutput({name, " valid after"}, {31'd0, valid_o}, 32'd0);
      checkOutput({name, " result held"}, result_o, exp);
    end
  endtask

  initial begin
    logic [31:0] corners[6];
    logic [2:0]  rf3;
    logic [31:0] ra, rb;
    logic [4:0]  rrd;
    logic        rrw;
    int          firstValid;

    vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, "MUL 7*-3"};
    vecs[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, "MULH min*min"};
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, "MULHU max*max"};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULHSU -1*max"};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, "DIV -7/2"};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, "REM -7/2"};
    vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        "DIVU 100/7"};
    vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         "REMU 100/7"};
    vecs[8]  = '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, "DIV 5/0"};
    vecs[9]  = '{3'd6, 32'd5,          32'd0,         32'd5,         "REM 5/0"};
    vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, "DIV ovf"};
    vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         "REM ovf"};
    vecs[12] = '{3'd6, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, "REM -7/0"};
    vecs[13] = '{3'd0, 32'd0,          32'h1234_5678, 32'd0,         "MUL 0*x"};

    corners[0] = 32'h0;
    corners[1] = 32'h1;
    corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h8000_0000;
    corners[4] = 32'h7FFF_FFFF;
    corners[5] = 32'h2;

    // Reset state
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("reset stall", {31'd0, stall_o}, 32'd0);
    checkOutput("reset valid", {31'd0, valid_o}, 32'd0);
    checkOutput("reset result", result_o, 32'd0);
    checkOutput("reset WRRD", {27'd0, WRRD_o}, 32'd0);
    checkOutput("reset RegWrite", {31'd0, RegWrite_o}, 32'd0);
    @(posedge clk_i);
    #1 rst_i = 1'b1;

    for (int i = 0; i < 14; i++)
      runOp(vecs[i].f3, vecs[i].a, vecs[i].b, 5'(i + 3), i[0], vecs[i].exp, vecs[i].name, 1'b0);

    // Non-M R-type ops must be ignored
    @(posedge clk_i);
    #1;
    start_i = 1'b1;
    func_i  = 10'b0000000000;
    data1_i = 32'd9;
    data2_i = 32'd9;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      checkOutput("ignored op stall", {31'd0, stall_o}, 32'd0);
      checkOutput("ignored op valid", {31'd0, valid_o}, 32'd0);
      if (i == 1) func_i = 10'b0100000000;
    end
    @(posedge clk_i);
    #1 start_i = 1'b0;

    // Asynchronous reset mid-operation
    applyStimulus(3'd0, 32'd123, 32'd456, 5'd17, 1'b1);
    repeat (11) @(negedge clk_i);
    rst_i   = 1'b0;
    start_i = 1'b0;
    #1;
    checkOutput("midreset stall", {31'd0, stall_o}, 32'd0);
    checkOutput("midreset valid", {31'd0, valid_o}, 32'd0);
    checkOutput("midreset result", result_o, 32'd0);
    checkOutput("midreset WRRD", {27'd0, WRRD_o}, 32'd0);
    checkOutput("midreset RegWrite", {31'd0, RegWrite_o}, 32'd0);
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    runOp(3'd3, 32'd3, 32'd4, 5'd9, 1'b1, 32'd0, "MULHU 3*4 after reset", 1'b0);

    // Back-to-back: second accept in the IDLE cycle right after DONE
    runOp(3'd0, 32'd6, 32'd7, 5'd1, 1'b1, 32'd42, "b2b MUL", 1'b1);
    firstValid = lastValidCyc;
    runOp(3'd5, 32'd42, 32'd6, 5'd2, 1'b1, 32'd7, "b2b DIVU", 1'b0);
    checkOutput("b2b valid spacing", lastValidCyc - firstValid, XLEN + 2);

    // Randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      rf3 = 3'($urandom_range(0, 7));
      ra  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 7) == 0) rb = rb & 32'h0000_00FF;
      rrd = 5'($urandom_range(0, 31));
      rrw = 1'($urandom_range(0, 1));
      runOp(rf3, ra, rb, rrd, rrw, refModel(rf3, ra, rb), $sformatf("rand%0d f3=%0d", i, rf3), 1'b0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the func code, forwarded operands, destination register and RegWrite held in ID/EX.
- Asserts a stall back to ID/EX and earlier stages while it computes, then presents one result cycle toward EX/MEM.
- Radix-2 shift-add multiply and restoring divide, one bit per cycle.

Parameters:
XLEN, 32, operand/result width
CNT_W, 6, iteration counter width (must hold XLEN)

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous reset, active-low
start_i  input  1  EX decoder: ID/EX holds a valid R-type op this cycle
func_i  input  10  {funct7, funct3} from ID/EX
data1_i  input  XLEN  forwarded rs1 operand
data2_i  input  XLEN  forwarded rs2 operand
WRRD_i  input  5  destination register
RegWrite_i  input  1  RegWrite control from ID/EX
stall_o  output  1  hold ID/EX and earlier stages
valid_o  output  1  result_o valid this cycle (one-cycle pulse)
result_o  output  XLEN  product/quotient/remainder
WRRD_o  output  5  latched destination register
RegWrite_o  output  1  latched RegWrite, gated by valid_o

Behaviour:
- Reset:
  - rst_i low asynchronously forces state IDLE.
  - Counter, operand/accumulator registers, result_o, WRRD_o, RegWrite_o and valid_o all go to 0.
  - stall_o = 0.
  - Reset mid-operation discards the operation.
- Accept: start_i=1 and func_i[9:3]==7'b0000001 and state IDLE.
  - Any other func with start_i is ignored: no stall, no valid.
- funct3 encoding:
  - 000 MUL (low), 001 MULH (s×s high), 010 MULHSU (s×u high), 011 MULHU (u×u high).
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- States: IDLE -> BUSY -> DONE -> IDLE.
  - IDLE: accept at cycle T. Latch magnitudes of the operands (signed ops use abs value; unsigned use the raw value), the result sign, funct3, WRRD_i and RegWrite_i. Counter = 0.
  - BUSY: one iteration per cycle. Counter increments. Leave when counter == XLEN-1, giving exactly XLEN BUSY cycles.
  - DONE: apply sign fixup, present result, go to IDLE next cycle. start_i is ignored in DONE, because ID/EX still holds the same instruction that cycle.
- stall_o, combinational:
  - High in IDLE when an accept condition holds.
  - High throughout BUSY.
  - Low in DONE.
  - Net effect: high cycles T..T+XLEN; ID/EX advances at the edge ending DONE.
- Latency: valid_o = 1 only in cycle T+XLEN+1 (T+33 at default).
- Outputs in DONE:
  - result_o, WRRD_o and RegWrite_o are held stable.
  - RegWrite_o = latched RegWrite & valid_o.
  - Outside DONE, valid_o = 0 and RegWrite_o = 0; result_o keeps its last value.
- Multiply:
  - 2·XLEN-bit unsigned accumulator of the magnitudes.
  - Negate the full 2·XLEN value if the sign bit is set, then select the low or high half.
- Divide:
  - Restoring algorithm on magnitudes.
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(dividend).
- Special cases, produced at DONE after the normal latency:
  - Divide by zero: quotient = all ones; remainder = dividend.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): quotient = 0x80000000; remainder = 0.
- Back-to-back: a new accept is possible in the IDLE cycle immediately after DONE.

Optional Feature:
MULDIV_EARLY_OUT_EN
- Defined: divide-by-zero, signed overflow, and either multiply operand == 0 skip BUSY. State goes IDLE->DONE, so valid_o = 1 at T+1 and stall_o is high only in cycle T. Results are identical to the normal path.
- Undefined: every accepted op takes the full XLEN+1 cycles.

Test Plan:
- MUL, data1=7, data2=0xFFFFFFFD -> stall_o high T..T+32; valid_o one pulse at T+33; result_o=0xFFFFFFEB; WRRD_o/RegWrite_o match inputs.
- MULH 0x80000000×0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Special cases, no macro, each valid at T+33:
  - DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
  - With MULDIV_EARLY_OUT_EN, the same ops give valid_o at T+1.
- Control/reset:
  - start_i with func=10'b0000000000 -> stall_o=0, valid_o never set.
  - start_i held through DONE -> exactly one result.
  - Drive rst_i low at T+10 -> all outputs 0 immediately.
  - A following MULHU 3×4 -> 0 at T'+33.
- Back-to-back MUL 6×7 then DIVU 42/6 -> results 42 then 7; valid_o pulses 34 cycles apart.
